spi_burst_sequencer: RTL and testbench
======================================

Name: spi_burst_sequencer

Overview:
- Host-side stage placed directly upstream of the SPI master. It buffers outgoing words in a TX FIFO and runs an N-word burst by holding SPIGo high, so SS stays asserted for the whole burst.
- It feeds each next word on SendData and collects every received word into an RX FIFO.
- The host sees plain FIFO write/read ports plus start/busy/done handshakes.

Parameters:
- WordLen, 8, SPI word width; must match the master.
- FifoDepth, 16, entries per FIFO; power of two, at least 2.
- LenW, 8, width of BurstLen.
- RxDly, 2, clk cycles from a WordFlg pulse until the master's ReceivedData is valid.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- TxWr  in  1  push TxData into the TX FIFO
- TxData  in  WordLen  word to transmit
- TxFull  out  1  TX FIFO full
- TxCount  out  clog2(FifoDepth)+1  TX FIFO occupancy
- RxRd  in  1  pop the RX FIFO
- RxData  out  WordLen  RX FIFO head, first-word-fall-through
- RxEmpty  out  1  RX FIFO empty
- Start  in  1  single-cycle burst request
- BurstLen  in  LenW  number of words in the burst
- Busy  out  1  burst in progress
- Done  out  1  one-cycle pulse at burst end
- StartErr  out  1  one-cycle pulse when a Start is rejected
- RxOvf  out  1  sticky flag; cleared by the next accepted Start
- SPIGo  out  1  master run request
- SendData  out  WordLen  word presented to the master
- WordFlg  in  1  master one-cycle pulse at the final sample edge of each word
- TxBusy  in  1  master transmit busy
- ReceivedData  in  WordLen  master received-word register

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; both FIFOs are emptied.
  - SPIGo, Busy, Done, StartErr and RxOvf are 0. SendData is 0.
  - Asserting reset mid-burst drops SPIGo in the same instant; FIFO contents are lost.
- TX FIFO:
  - A write while full is ignored, and the count is unchanged.
  - A write is legal during a burst.
  - Read and write pointers wrap modulo FifoDepth.
  - A simultaneous push and pop leaves the count unchanged.
- RX FIFO:
  - RxRd while empty is ignored.
  - A capture while full drops the word and sets RxOvf.
  - A simultaneous host pop and capture on a full FIFO succeeds with no overflow.
- FSM states: IDLE, LOAD, XFER, STOP, DONE.
- IDLE:
  - Start with BurstLen==0, or with TxCount<BurstLen, is rejected: StartErr pulses the next cycle and the FSM stays in IDLE.
  - Otherwise go to LOAD. The burst counter is set to BurstLen and RxOvf is cleared.
  - A Start received outside IDLE is ignored, with no StartErr.
- LOAD (1 cycle):
  - Pop the TX head into the SendData register.
  - Assert SPIGo and Busy, then go to XFER.
- XFER:
  - SPIGo stays high.
  - On each WordFlg, decrement the remaining-word counter.
  - If words remain, pop the next TX word into SendData on the cycle after WordFlg. SendData then holds stable until the next WordFlg.
- Capture pipeline:
  - Each WordFlg launches an RxDly-cycle delay chain (shift register).
  - At the chain output, ReceivedData is pushed into the RX FIFO.
  - Consecutive words never overlap: word time is greater than RxDly.
- XFER to STOP:
  - On the WordFlg that brings the counter to 0, SPIGo deasserts on the next cycle.
- STOP:
  - Wait until TxBusy==0 and the capture chain is empty, then go to DONE.
- DONE (1 cycle):
  - Done=1 and Busy=0 at the next edge, then return to IDLE.
- Busy is high from LOAD through STOP inclusive.
- The TX FIFO is never popped when it is empty. This is guaranteed by the start check, because the FSM is the only consumer.

Test Plan:
- Reset state: reset low with TxWr and Start held high -> SPIGo=0, Busy=0, TxCount=0, RxEmpty=1, StartErr=0.
- Single-word burst:
  - Stimulus: write 0xA5, Start with BurstLen=1; master model returns 0x3C.
  - Required: SendData=0xA5 while SPIGo is high; SPIGo falls 1 cycle after WordFlg; Done pulses once; RxData=0x3C; TxCount=0.
- Four-word burst:
  - Stimulus: TX words 0x01,0x02,0x03,0x04, BurstLen=4; loopback model.
  - Required: SPIGo continuous across all 4 WordFlg pulses; SendData sequence is 01,02,03,04; RX pops return 01..04 in order.
- Start rejection:
  - Stimulus: 2 words queued, Start with BurstLen=3, then a separate Start with BurstLen=0.
  - Required: StartErr pulses for each request; SPIGo stays 0; TxCount stays 2.
- FIFO boundaries:
  - Stimulus: 17 writes with FifoDepth=16.
  - Required: TxFull=1 after the 16th write; the 17th write is ignored.
  - Stimulus: a 16-word burst with 1 RX entry pre-filled and no host reads.
  - Required: RxOvf=1 and 16 words held; the next accepted Start clears RxOvf.
- Mid-burst reset: reset asserted 3 cycles after the second WordFlg of a 4-word burst -> SPIGo=0 asynchronously; FSM in IDLE; both FIFOs empty; no Done pulse.

Source files
------------

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer
//   Host-side stage that sits in front of an SPI master. The host pushes words
//   into a TX FIFO and requests an N-word burst with Start/BurstLen. The
//   sequencer holds SPIGo high for the whole burst, so the slave select stays
//   asserted. It presents each word on SendData and collects every received
//   word into an RX FIFO.
//
// Ports
//   clk, reset        system clock, asynchronous active-low reset
//   TxWr, TxData      TX FIFO push; TxFull, TxCount report TX occupancy
//   RxRd, RxData      RX FIFO pop and first-word-fall-through head; RxEmpty
//   Start, BurstLen   burst request; Busy/Done/StartErr handshakes
//   RxOvf             sticky RX overflow, cleared by the next accepted Start
//   SPIGo, SendData   run request and transmit word towards the master
//   WordFlg, TxBusy,  per-word strobe, busy flag and receive register
//   ReceivedData      coming back from the master
module spi_burst_sequencer #(
  parameter int WordLen   = 8,
  parameter int FifoDepth = 16,
  parameter int LenW      = 8,
  parameter int RxDly     = 2,
  localparam int AW       = $clog2(FifoDepth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               TxWr,
  input  logic [WordLen-1:0] TxData,
  output logic               TxFull,
  output logic [AW:0]        TxCount,
  input  logic               RxRd,
  output logic [WordLen-1:0] RxData,
  output logic               RxEmpty,
  input  logic               Start,
  input  logic [LenW-1:0]    BurstLen,
  output logic               Busy,
  output logic               Done,
  output logic               StartErr,
  output logic               RxOvf,
  output logic               SPIGo,
  output logic [WordLen-1:0] SendData,
  input  logic               WordFlg,
  input  logic               TxBusy,
  input  logic [WordLen-1:0] ReceivedData
);

  typedef enum logic [2:0] {IDLE, LOAD, XFER, STOP, DONE} state_e;

  state_e state_q, state_d;

  logic [WordLen-1:0] txMem_q [FifoDepth];
  logic [AW-1:0]      txWrPtr_q, txRdPtr_q;
  logic [AW:0]        txCount_q;
  logic               txPush, txPop;

  logic [WordLen-1:0] rxMem_q [FifoDepth];
  logic [AW-1:0]      rxWrPtr_q, rxRdPtr_q;
  logic [AW:0]        rxCount_q;
  logic               rxPush, rxPop, rxFull, rxOvfSet;

  logic [LenW-1:0]    remain_q;
  logic               pend_q;
  logic [WordLen-1:0] sendData_q;
  logic [RxDly-1:0]   capChain_q;
  logic               startErr_q, rxOvf_q;
  logic               spiGo_q, spiGo_d, busy_q, busy_d, done_q, done_d;

  logic               startAccept, startReject, flgXfer, capture;

  // ---------------- TX FIFO ----------------
  assign TxFull  = (txCount_q == (AW+1)'(FifoDepth));
  assign TxCount = txCount_q;
  assign txPush  = TxWr && !TxFull;
  // The FSM is the only consumer; the start check guarantees it never pops empty.
  assign txPop   = (state_q == LOAD) || pend_q;

  always_ff @(posedge clk) begin
    if (txPush) txMem_q[txWrPtr_q] <= TxData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      txCount_q <= '0;
    end else begin
      if (txPush) txWrPtr_q <= txWrPtr_q + AW'(1);
      if (txPop)  txRdPtr_q <= txRdPtr_q + AW'(1);
      case ({txPush, txPop})
        2'b10:   txCount_q <= txCount_q + (AW+1)'(1);
        2'b01:   txCount_q <= txCount_q - (AW+1)'(1);
        default: txCount_q <= txCount_q;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  assign RxEmpty  = (rxCount_q == '0);
  assign rxFull   = (rxCount_q == (AW+1)'(FifoDepth));
  assign RxData   = rxMem_q[rxRdPtr_q];
  assign rxPop    = RxRd && !RxEmpty;
  assign capture  = capChain_q[RxDly-1];
  // A pop in the same cycle frees the slot, so a capture on a full FIFO still lands.
  assign rxPush   = capture && (!rxFull || rxPop);
  assign rxOvfSet = capture && rxFull && !rxPop;

  always_ff @(posedge clk) begin
    if (rxPush) rxMem_q[rxWrPtr_q] <= ReceivedData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxWrPtr_q <= '0;
      rxRdPtr_q <= '0;
      rxCount_q <= '0;
    end else begin
      if (rxPush) rxWrPtr_q <= rxWrPtr_q + AW'(1);
      if (rxPop)  rxRdPtr_q <= rxRdPtr_q + AW'(1);
      case ({rxPush, rxPop})
        2'b10:   rxCount_q <= rxCount_q + (AW+1)'(1);
        2'b01:   rxCount_q <= rxCount_q - (AW+1)'(1);
        default: rxCount_q <= rxCount_q;
      endcase
    end
  end

  // ---------------- burst control ----------------
  assign flgXfer     = WordFlg && (state_q == XFER);
  assign startReject = Start && (state_q == IDLE) &&
                       ((BurstLen == '0) || (32'(txCount_q) < 32'(BurstLen)));
  assign startAccept = Start && (state_q == IDLE) && !startReject;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remain_q   <= '0;
      pend_q     <= 1'b0;
      sendData_q <= '0;
      capChain_q <= '0;
      startErr_q <= 1'b0;
      rxOvf_q    <= 1'b0;
    end else begin
      if (startAccept)  remain_q <= BurstLen;
      else if (flgXfer) remain_q <= remain_q - LenW'(1);
      // The next word is popped on the cycle after WordFlg, only if words remain.
      pend_q     <= flgXfer && (remain_q != LenW'(1));
      if (txPop) sendData_q <= txMem_q[txRdPtr_q];
      // Each WordFlg walks through RxDly stages until ReceivedData is valid.
      capChain_q <= (capChain_q << 1) | RxDly'(flgXfer);
      startErr_q <= startReject;
      if (startAccept)   rxOvf_q <= 1'b0;
      else if (rxOvfSet) rxOvf_q <= 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      spiGo_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spiGo_q <= spiGo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startAccept) state_d = LOAD;
      LOAD:    state_d = XFER;
      XFER:    if (WordFlg && (remain_q == LenW'(1))) state_d = STOP;
      STOP:    if (!TxBusy && (capChain_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so SPIGo rises together with
  // the first SendData word and falls the cycle after the final WordFlg.
  always_comb begin
    spiGo_d = (state_d == XFER);
    busy_d  = (state_d == LOAD) || (state_d == XFER) || (state_d == STOP);
    done_d  = (state_d == DONE);
  end

  assign SPIGo    = spiGo_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign StartErr = startErr_q;
  assign RxOvf    = rxOvf_q;
  assign SendData = sendData_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Self-checking bench for spi_burst_sequencer. A behavioural SPI master answers
// the SPIGo request, and queues model the TX FIFO, the RX FIFO and the overflow flag.
module tb_spi_burst_sequencer;

  logic       clk, reset;
  logic       TxWr, RxRd, Start, WordFlg, TxBusy;
  logic [7:0] TxData, BurstLen, ReceivedData;
  logic       TxFull, RxEmpty, Busy, Done, StartErr, RxOvf, SPIGo;
  logic [4:0] TxCount;
  logic [7:0] RxData, SendData;

  int checks = 0;
  int failures = 0;

  logic [7:0] txModel[$];
  logic [7:0] rxModel[$];
  logic [7:0] sentQ[$];
  bit         ovfModel = 0;
  bit         loopback = 1;
  logic [7:0] fixedRx = 8'h00;

  spi_burst_sequencer #(.WordLen(8), .FifoDepth(16), .LenW(8), .RxDly(2)) dut (
    .clk(clk), .reset(reset),
    .TxWr(TxWr), .TxData(TxData), .TxFull(TxFull), .TxCount(TxCount),
    .RxRd(RxRd), .RxData(RxData), .RxEmpty(RxEmpty),
    .Start(Start), .BurstLen(BurstLen), .Busy(Busy), .Done(Done),
    .StartErr(StartErr), .RxOvf(RxOvf), .SPIGo(SPIGo), .SendData(SendData),
    .WordFlg(WordFlg), .TxBusy(TxBusy), .ReceivedData(ReceivedData)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always ends on its own
  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison goes through here
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // SPI master model: a word takes 6 clocks. It samples SendData two clocks in,
  // strobes WordFlg at the end and presents the received word with the strobe.
  // It keeps going word after word as long as SPIGo is still high.
  initial begin
    int mPhase;
    logic [7:0] mWord;
    mPhase = 0;
    mWord = 8'h00;
    TxBusy = 1'b0;
    WordFlg = 1'b0;
    ReceivedData = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        TxBusy = 1'b0;
        WordFlg = 1'b0;
        mPhase = 0;
      end else if (mPhase == 0) begin
        if (SPIGo) begin
          TxBusy = 1'b1;
          mPhase = 1;
        end
      end else begin
        mPhase++;
        if (mPhase == 3) begin
          mWord = SendData;
          sentQ.push_back(SendData);
        end
        if (mPhase == 6) begin
          WordFlg = 1'b1;
          ReceivedData = loopback ? mWord : fixedRx;
        end
        if (mPhase == 7) begin
          WordFlg = 1'b0;
          if (SPIGo) mPhase = 1;
          else begin
            TxBusy = 1'b0;
            mPhase = 0;
          end
        end
      end
    end
  end

  // Push one word and compare occupancy and the full flag against the model
  task automatic writeWord(input logic [7:0] w);
    @(negedge clk);
    TxWr = 1'b1;
    TxData = w;
    @(negedge clk);
    TxWr = 1'b0;
    if (txModel.size() < 16) txModel.push_back(w);
    checkOutput("tx_count", 32'(TxCount), 32'(txModel.size()));
    checkOutput("tx_full", 32'(TxFull), 32'(txModel.size() == 16));
  endtask

  // Pop one RX word (if the model holds any) and compare the FWFT head
  task automatic readWord();
    @(negedge clk);
    checkOutput("rx_empty", 32'(RxEmpty), 32'(rxModel.size() == 0));
    if (rxModel.size() > 0) begin
      checkOutput("rx_data", 32'(RxData), 32'(rxModel[0]));
      void'(rxModel.pop_front());
      RxRd = 1'b1;
      @(negedge clk);
      RxRd = 1'b0;
    end
  endtask

  // Request a burst and follow it to Done, checking SPIGo after every WordFlg,
  // the words the master saw, and the RX/overflow outcome
  task automatic applyStimulus(input int len);
    bit accept;
    bit sawDone;
    bit prevFlg;
    int flgSeen;
    logic [7:0] expSent[$];
    accept = (len != 0) && (txModel.size() >= len);
    sentQ.delete();
    @(negedge clk);
    Start = 1'b1;
    BurstLen = 8'(len);
    @(negedge clk);
    Start = 1'b0;
    checkOutput("start_err", 32'(StartErr), 32'(!accept));
    checkOutput("busy_after_start", 32'(Busy), 32'(accept));
    if (!accept) begin
      checkOutput("spigo_rejected", 32'(SPIGo), 32'(0));
      @(negedge clk);
      checkOutput("start_err_pulse", 32'(StartErr), 32'(0));
      checkOutput("tx_count_rejected", 32'(TxCount), 32'(txModel.size()));
      return;
    end
    ovfModel = 0;
    checkOutput("rxovf_cleared", 32'(RxOvf), 32'(0));
    for (int i = 0; i < len; i++) expSent.push_back(txModel.pop_front());
    sawDone = 0;
    prevFlg = 0;
    flgSeen = 0;
    for (int c = 0; (c < len * 12 + 40) && !sawDone; c++) begin
      @(negedge clk);
      if (prevFlg) begin
        flgSeen++;
        checkOutput("spigo_after_flg", 32'(SPIGo), 32'(flgSeen < len));
      end
      prevFlg = WordFlg;
      if (Done) sawDone = 1;
      else checkOutput("busy_in_burst", 32'(Busy), 32'(1));
    end
    checkOutput("done_seen", 32'(sawDone), 32'(1));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(Done), 32'(0));
    checkOutput("busy_end", 32'(Busy), 32'(0));
    checkOutput("word_count", 32'(sentQ.size()), 32'(len));
    for (int i = 0; i < len && i < sentQ.size(); i++)
      checkOutput("send_data", 32'(sentQ[i]), 32'(expSent[i]));
    for (int i = 0; i < len; i++) begin
      if (rxModel.size() < 16) rxModel.push_back(loopback ? expSent[i] : fixedRx);
      else ovfModel = 1;
    end
    checkOutput("rx_ovf", 32'(RxOvf), 32'(ovfModel));
    checkOutput("tx_count_end", 32'(TxCount), 32'(txModel.size()));
  endtask

  initial begin
    int nw, len, nr, flg;
    reset = 1'b0;
    TxWr = 1'b1;
    TxData = 8'h55;
    RxRd = 1'b0;
    Start = 1'b1;
    BurstLen = 8'd1;

    // Reset with write and start held high
    repeat (3) @(negedge clk);
    checkOutput("reset_spigo", 32'(SPIGo), 32'(0));
    checkOutput("reset_busy", 32'(Busy), 32'(0));
    checkOutput("reset_txcount", 32'(TxCount), 32'(0));
    checkOutput("reset_rxempty", 32'(RxEmpty), 32'(1));
    checkOutput("reset_starterr", 32'(StartErr), 32'(0));
    checkOutput("reset_done", 32'(Done), 32'(0));
    checkOutput("reset_rxovf", 32'(RxOvf), 32'(0));
    checkOutput("reset_senddata", 32'(SendData), 32'(0));
    TxWr = 1'b0;
    Start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_txcount", 32'(TxCount), 32'(0));

    // Single-word burst with a fixed reply
    loopback = 0;
    fixedRx = 8'h3C;
    writeWord(8'hA5);
    applyStimulus(1);
    readWord();

    // Four-word loopback burst
    loopback = 1;
    for (int i = 1; i <= 4; i++) writeWord(8'(i));
    applyStimulus(4);
    for (int i = 0; i < 4; i++) readWord();
    readWord();

    // Start rejection: too few words, then zero length, then drain
    writeWord(8'h11);
    writeWord(8'h22);
    applyStimulus(3);
    applyStimulus(0);
    applyStimulus(2);
    readWord();
    readWord();

    // FIFO boundaries: one RX entry pre-filled, TX filled past full, 16-word burst
    writeWord(8'h77);
    applyStimulus(1);
    for (int i = 0; i < 17; i++) writeWord(8'(8'h80 + i));
    applyStimulus(16);
    for (int i = 0; i < 17; i++) readWord();
    checkOutput("rx_ovf_sticky", 32'(RxOvf), 32'(1));
    writeWord(8'hC3);
    applyStimulus(1);
    readWord();

    // Randomized bursts against the queue model
    for (int it = 0; it < 12; it++) begin
      loopback = bit'($urandom_range(0, 1));
      fixedRx = 8'($urandom);
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) writeWord(8'($urandom));
      len = $urandom_range(0, txModel.size() + 1);
      applyStimulus(len);
      nr = $urandom_range(0, rxModel.size() + 1);
      for (int i = 0; i < nr; i++) readWord();
    end

    // Mid-burst reset, 3 cycles after the second WordFlg of a 4-word burst
    while (rxModel.size() > 0) readWord();
    loopback = 1;
    for (int i = 0; i < 4; i++) writeWord(8'(8'hE0 + i));
    while (txModel.size() > 4) void'(txModel.pop_front());
    @(negedge clk);
    Start = 1'b1;
    BurstLen = 8'(txModel.size());
    @(negedge clk);
    Start = 1'b0;
    flg = 0;
    for (int c = 0; c < 200 && flg < 2; c++) begin
      @(negedge clk);
      if (WordFlg) flg++;
    end
    checkOutput("second_flg_seen", 32'(flg), 32'(2));
    checkOutput("spigo_before_reset", 32'(SPIGo), 32'(1));
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_spigo", 32'(SPIGo), 32'(0));
    checkOutput("async_reset_busy", 32'(Busy), 32'(0));
    @(negedge clk);
    checkOutput("reset_mid_txcount", 32'(TxCount), 32'(0));
    checkOutput("reset_mid_rxempty", 32'(RxEmpty), 32'(1));
    checkOutput("reset_mid_done", 32'(Done), 32'(0));
    txModel.delete();
    rxModel.delete();
    ovfModel = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput("no_done_after_reset", 32'(Done), 32'(0));
    end
    // A rejected Start proves the FSM sits in IDLE
    applyStimulus(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
